rs_beat_packer: RTL

//  Upstream feeder of the syndrome slices: accepts a byte-serial RS(255/256) codeword stream

---
 rtl/rs_pkg.sv | 19 +
 rtl/rs_beat_packer_if.sv | 29 ++
 rtl/rs_beat_packer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/rs_pkg.sv
// Shared constants and state type for the RS beat packer: symbol width, codeword
// and beat geometry, and the packer FSM encoding.
package rs_pkg;

    localparam int RS_SYM_W        = 8;
    localparam int RS_CW_BYTES     = 256;
    localparam int RS_BEAT_BYTES   = 16;
    localparam int RS_BEATS_PER_CW = 16;
    localparam int RS_BEAT_W       = RS_SYM_W * RS_BEAT_BYTES;

    localparam logic [RS_SYM_W-1:0] RS_PAD_BYTE = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        PAD  = 2'd2
    } rs_state_t;

endpackage

// File: rtl/rs_beat_packer_if.sv
// Byte-serial input stream and packed-beat output bus of the RS beat packer.
// Byte side: a byte transfers on a rising edge where byte_valid and byte_ready are both
// high; sop/eop are meaningful only with byte_valid. Beat side has no backpressure:
// valid_out is a one-cycle strobe and data_out/sop_out/eop_out qualify with it.
interface rs_beat_packer_if;
    import rs_pkg::*;

    logic [RS_SYM_W-1:0]  byte_in;
    logic                 byte_valid;
    logic                 byte_sop;
    logic                 byte_eop;
    logic                 byte_ready;
    logic [RS_BEAT_W-1:0] data_out;
    logic                 valid_out;
    logic                 sop_out;
    logic                 eop_out;
    logic                 len_err;

    modport master (
        output byte_in, byte_valid, byte_sop, byte_eop,
        input  byte_ready, data_out, valid_out, sop_out, eop_out, len_err
    );

    modport slave (
        input  byte_in, byte_valid, byte_sop, byte_eop,
        output byte_ready, data_out, valid_out, sop_out, eop_out, len_err
    );

endinterface

// File: rtl/rs_beat_packer.sv
// Packs a byte-serial 256-byte RS codeword into 16 beats of 16 bytes each.
// Optional macro RS_SHORTENED_PAD_EN: early eop pads the rest of the codeword with PAD_BYTE.
module rs_beat_packer
    import rs_pkg::*;
#(
    parameter logic [RS_SYM_W-1:0] PAD_BYTE = RS_PAD_BYTE
) (
    input  logic             clk,
    input  logic             rst_n,
    rs_beat_packer_if.slave  bus,
    output rs_state_t        o_dbg_state
);

    rs_state_t r_state;
    rs_state_t w_next_state;
    logic [3:0] r_lane;
    logic [3:0] r_beat;
    logic [3:0] w_next_lane;
    logic [3:0] w_next_beat;
    logic [RS_BEAT_BYTES-1:0][RS_SYM_W-1:0] r_hold;
    logic [RS_BEAT_BYTES-1:0][RS_SYM_W-1:0] w_fill_beat;

    logic                 r_ready;
    logic [RS_BEAT_W-1:0] r_data;
    logic                 r_valid;
    logic                 r_sop;
    logic                 r_eop;
    logic                 r_len_err;

    logic                 w_accept;
    logic                 w_take;
    logic                 w_idx_first;
    logic                 w_idx_last;
    logic                 w_early_eop;
    logic                 w_emit;
    logic                 w_emit_sop;
    logic                 w_emit_eop;
    logic [RS_BEAT_W-1:0] w_emit_data;
    logic                 w_len_err;

    assign w_accept    = bus.byte_valid & r_ready;
    // In IDLE only a sop byte opens a frame; anything else is dropped.
    assign w_take      = w_accept & ((r_state == FILL) | bus.byte_sop);
    assign w_idx_first = (r_lane == 4'd0) && (r_beat == 4'd0);
    assign w_idx_last  = (r_lane == 4'd15) && (r_beat == 4'd15);
    assign w_early_eop = bus.byte_eop & ~w_idx_last;

    // Beat as it would look if the incoming byte closed it; lanes above it take the pad value.
    always_comb begin
        for (int j = 0; j < RS_BEAT_BYTES; j++) begin
            if (4'(j) < r_lane) begin
                w_fill_beat[j] = r_hold[j];
            end else if (4'(j) == r_lane) begin
                w_fill_beat[j] = bus.byte_in;
            end else begin
                w_fill_beat[j] = PAD_BYTE;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_lane  = r_lane;
        w_next_beat  = r_beat;
        w_emit       = 1'b0;
        w_emit_sop   = 1'b0;
        w_emit_eop   = 1'b0;
        w_emit_data  = w_fill_beat;
        w_len_err    = 1'b0;

        if (r_state == PAD) begin
            w_emit      = 1'b1;
            w_emit_eop  = (r_beat == 4'd15);
            w_emit_data = {RS_BEAT_BYTES{PAD_BYTE}};
            w_next_beat = r_beat + 4'd1;
            if (r_beat == 4'd15) begin
                w_next_state = IDLE;
            end
        end else if (w_take) begin
            w_emit_sop = (r_beat == 4'd0);
            w_emit_eop = (r_beat == 4'd15);
            if (bus.byte_sop && !w_idx_first) begin
                w_len_err = 1'b1;
            end
            if (w_idx_last && !bus.byte_eop) begin
                w_len_err = 1'b1;
            end
`ifndef RS_SHORTENED_PAD_EN
            if (w_early_eop) begin
                w_len_err = 1'b1;
            end
`endif
            if (w_idx_last) begin
                w_emit       = 1'b1;
                w_next_state = IDLE;
                w_next_lane  = 4'd0;
                w_next_beat  = 4'd0;
`ifdef RS_SHORTENED_PAD_EN
            end else if (w_early_eop) begin
                w_emit      = 1'b1;
                w_next_lane = 4'd0;
                w_next_beat = r_beat + 4'd1;
                w_next_state = (r_beat == 4'd15) ? IDLE : PAD;
`endif
            end else if (r_lane == 4'd15) begin
                w_emit       = 1'b1;
                w_next_state = FILL;
                w_next_lane  = 4'd0;
                w_next_beat  = r_beat + 4'd1;
            end else begin
                w_next_state = FILL;
                w_next_lane  = r_lane + 4'd1;
            end
        end else if (w_accept) begin
            w_len_err = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_lane    <= 4'd0;
            r_beat    <= 4'd0;
            r_hold    <= '0;
            r_ready   <= 1'b0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_sop     <= 1'b0;
            r_eop     <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_lane    <= w_next_lane;
            r_beat    <= w_next_beat;
            if (w_take) begin
                r_hold[r_lane] <= bus.byte_in;
            end
            if (w_emit) begin
                r_data <= w_emit_data;
            end
            r_valid   <= w_emit;
            r_sop     <= w_emit & w_emit_sop;
            r_eop     <= w_emit & w_emit_eop;
            r_len_err <= w_len_err;
`ifdef RS_SHORTENED_PAD_EN
            // Held low through the whole pad run, including the cycle the last pad beat is out.
            r_ready   <= (w_next_state != PAD) && (r_state != PAD);
`else
            r_ready   <= 1'b1;
`endif
        end
    end

    assign bus.byte_ready = r_ready;
    assign bus.data_out   = r_data;
    assign bus.valid_out  = r_valid;
    assign bus.sop_out    = r_sop;
    assign bus.eop_out    = r_eop;
    assign bus.len_err    = r_len_err;
    assign o_dbg_state    = r_state;

endmodule
